// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and trap-sequencing controller for the in-order pipeline.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int STAGES     = 2,
    parameter int LOAD_STAGE = 1,
    parameter int XLEN       = 32,
    parameter int FSEL_W     = $clog2(STAGES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [4:0]        d_rs1,
    input  logic [4:0]        d_rs2,
    input  logic              d_rs1_used,
    input  logic              d_rs2_used,
    input  logic [4:0]        d_rd,
    input  logic              d_reg_we,
    input  logic              d_is_load,
    input  logic              d_is_mret,
    input  logic [XLEN-1:0]   d_pc,
    input  logic              s0_branch_taken,
    input  logic              irq,
    input  logic              irq_en,
    output logic [FSEL_W-1:0] fwd_sel_a,
    output logic [FSEL_W-1:0] fwd_sel_b,
    output logic              stall_if,
    output logic              stall_d,
    output logic              flush_d,
    output logic              trap_take,
    output logic              mret_take,
    output logic [XLEN-1:0]   epc,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [STAGES-1:0] r_sb_valid;
    logic [STAGES-1:0] r_sb_we;
    logic [STAGES-1:0] r_sb_load;
    logic [4:0]        r_sb_rd [STAGES];
    logic [XLEN-1:0]   r_epc;

    logic [FSEL_W-1:0] w_sel_a;
    logic [FSEL_W-1:0] w_sel_b;
    logic              w_haz_a;
    logic              w_haz_b;
    logic              w_load_use;
    logic              w_irq_go;
    logic              w_issue;
    logic              w_stall_if;
    logic              w_stall_d;
    logic              w_flush_d;
    logic              w_trap_take;
    logic              w_mret_take;

    // Forwarding lookup: scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        w_sel_a = {FSEL_W{1'b0}};
        w_sel_b = {FSEL_W{1'b0}};
        w_haz_a = 1'b0;
        w_haz_b = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (d_rs1_used && (d_rs1 != 5'd0) && r_sb_valid[k] && r_sb_we[k] && (r_sb_rd[k] == d_rs1)) begin
                if (r_sb_load[k] && (k < LOAD_STAGE)) begin
                    w_haz_a = 1'b1;
                    w_sel_a = {FSEL_W{1'b0}};
                end else begin
                    w_haz_a = 1'b0;
                    w_sel_a = FSEL_W'(k + 1);
                end
            end else begin
                w_haz_a = w_haz_a;
            end
            if (d_rs2_used && (d_rs2 != 5'd0) && r_sb_valid[k] && r_sb_we[k] && (r_sb_rd[k] == d_rs2)) begin
                if (r_sb_load[k] && (k < LOAD_STAGE)) begin
                    w_haz_b = 1'b1;
                    w_sel_b = {FSEL_W{1'b0}};
                end else begin
                    w_haz_b = 1'b0;
                    w_sel_b = FSEL_W'(k + 1);
                end
            end else begin
                w_haz_b = w_haz_b;
            end
        end
    end

    assign w_load_use = d_valid & (w_haz_a | w_haz_b);

    // Next-state and control outputs; a taken branch always overrides a load-use stall.
    always_comb begin
        w_state_nxt = r_state;
        w_stall_if  = 1'b0;
        w_stall_d   = 1'b0;
        w_flush_d   = 1'b0;
        w_trap_take = 1'b0;
        w_mret_take = 1'b0;
        w_irq_go    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_irq_go    = irq & irq_en & d_valid & ~s0_branch_taken & ~w_load_use;
                w_stall_if  = w_load_use & ~s0_branch_taken;
                w_stall_d   = w_load_use & ~s0_branch_taken;
                w_mret_take = d_is_mret & d_valid & ~w_load_use & ~s0_branch_taken & ~w_irq_go;
                w_flush_d   = s0_branch_taken | w_mret_take;
                w_issue     = d_valid & ~w_stall_d & ~w_flush_d & ~w_irq_go;
                if (w_irq_go) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                w_stall_if = 1'b1;
                w_stall_d  = ~s0_branch_taken;
                w_flush_d  = s0_branch_taken;
                if (r_sb_valid == {STAGES{1'b0}}) begin
                    w_state_nxt = ST_TRAP;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_TRAP: begin
                w_trap_take = 1'b1;
                w_flush_d   = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // FSM state and saved exception PC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_epc   <= {XLEN{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_irq_go) begin
                r_epc <= d_pc;
            end else begin
                r_epc <= r_epc;
            end
        end
    end

    // Scoreboard shift register; S0 takes the issued instruction or a bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sb_valid <= {STAGES{1'b0}};
            r_sb_we    <= {STAGES{1'b0}};
            r_sb_load  <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                r_sb_rd[i] <= 5'd0;
            end
        end else begin
            r_sb_valid <= {r_sb_valid[STAGES-2:0], w_issue};
            r_sb_we    <= {r_sb_we[STAGES-2:0], w_issue & d_reg_we};
            r_sb_load  <= {r_sb_load[STAGES-2:0], w_issue & d_is_load};
            r_sb_rd[0] <= w_issue ? d_rd : 5'd0;
            for (int i = 1; i < STAGES; i++) begin
                r_sb_rd[i] <= r_sb_rd[i-1];
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Free-running wrap-around event counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_stall <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            r_perf_stall <= w_stall_d ? (r_perf_stall + 32'd1) : r_perf_stall;
            r_perf_flush <= w_flush_d ? (r_perf_flush + 32'd1) : r_perf_flush;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

    assign fwd_sel_a = w_sel_a;
    assign fwd_sel_b = w_sel_b;
    assign stall_if  = w_stall_if;
    assign stall_d   = w_stall_d;
    assign flush_d   = w_flush_d;
    assign trap_take = w_trap_take;
    assign mret_take = w_mret_take;
    assign epc       = r_epc;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (2/1 and 4/2 stages) against an age-indexed reference model.
module tb_pipeline_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        d_valid, d_rs1_used, d_rs2_used, d_reg_we, d_is_load, d_is_mret;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [31:0] d_pc;
    logic        s0_branch_taken, irq, irq_en;

    logic [1:0]  fsa0, fsb0;
    logic [2:0]  fsa1, fsb1;
    logic        sif0, sd0, fl0, tr0, mr0, sif1, sd1, fl1, tr1, mr1;
    logic [31:0] epc0, psc0, pfc0, epc1, psc1, pfc1;

    logic [31:0] o_sa [2], o_sb [2], o_sif [2], o_sd [2], o_fl [2], o_tr [2], o_mr [2];
    logic [31:0] o_epc [2], o_psc [2], o_pfc [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.STAGES(2), .LOAD_STAGE(1), .XLEN(32)) u_dut0 (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_reg_we(d_reg_we),
        .d_is_load(d_is_load), .d_is_mret(d_is_mret), .d_pc(d_pc), .s0_branch_taken(s0_branch_taken),
        .irq(irq), .irq_en(irq_en), .fwd_sel_a(fsa0), .fwd_sel_b(fsb0), .stall_if(sif0), .stall_d(sd0),
        .flush_d(fl0), .trap_take(tr0), .mret_take(mr0), .epc(epc0),
        .perf_stall_cnt(psc0), .perf_flush_cnt(pfc0));

    pipeline_hazard_ctrl #(.STAGES(4), .LOAD_STAGE(2), .XLEN(32)) u_dut1 (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_reg_we(d_reg_we),
        .d_is_load(d_is_load), .d_is_mret(d_is_mret), .d_pc(d_pc), .s0_branch_taken(s0_branch_taken),
        .irq(irq), .irq_en(irq_en), .fwd_sel_a(fsa1), .fwd_sel_b(fsb1), .stall_if(sif1), .stall_d(sd1),
        .flush_d(fl1), .trap_take(tr1), .mret_take(mr1), .epc(epc1),
        .perf_stall_cnt(psc1), .perf_flush_cnt(pfc1));

    assign o_sa[0] = 32'(fsa0);  assign o_sa[1] = 32'(fsa1);
    assign o_sb[0] = 32'(fsb0);  assign o_sb[1] = 32'(fsb1);
    assign o_sif[0] = 32'(sif0); assign o_sif[1] = 32'(sif1);
    assign o_sd[0] = 32'(sd0);   assign o_sd[1] = 32'(sd1);
    assign o_fl[0] = 32'(fl0);   assign o_fl[1] = 32'(fl1);
    assign o_tr[0] = 32'(tr0);   assign o_tr[1] = 32'(tr1);
    assign o_mr[0] = 32'(mr0);   assign o_mr[1] = 32'(mr1);
    assign o_epc[0] = epc0;      assign o_epc[1] = epc1;
    assign o_psc[0] = psc0;      assign o_psc[1] = psc1;
    assign o_pfc[0] = pfc0;      assign o_pfc[1] = pfc1;

    // Reference model: in-flight instructions indexed by age since issue; mode 0 run, 1 draining, 2 trap.
    bit          m_v   [2][8];
    bit   [4:0]  m_rd  [2][8];
    bit          m_we  [2][8];
    bit          m_ld  [2][8];
    int          m_mode [2];
    bit   [31:0] m_epc [2];
    bit   [31:0] m_cs  [2];
    bit   [31:0] m_cf  [2];

    function automatic int st_of(int u);
        return (u == 0) ? 2 : 4;
    endfunction

    function automatic int ls_of(int u);
        return (u == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < 8; a++) begin
                m_v[u][a] = 1'b0; m_rd[u][a] = 5'd0; m_we[u][a] = 1'b0; m_ld[u][a] = 1'b0;
            end
            m_mode[u] = 0; m_epc[u] = 32'd0; m_cs[u] = 32'd0; m_cf[u] = 32'd0;
        end
    endtask

    task automatic lookup(input int u, input bit used, input bit [4:0] rs, output int sel, output bit haz);
        sel = 0;
        haz = 1'b0;
        if (used && rs != 5'd0) begin
            for (int a = 0; a < st_of(u); a++) begin
                if (m_v[u][a] && m_we[u][a] && m_rd[u][a] == rs) begin
                    if (m_ld[u][a] && a < ls_of(u)) haz = 1'b1;
                    else sel = a + 1;
                    break;
                end
            end
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Compare every output of both instances with the model, advance the model, move to the next negedge.
    task automatic step();
        for (int u = 0; u < 2; u++) begin
            int sa, sb;
            bit ha, hb, br, lu, go, e_sif, e_sd, e_fl, e_tr, e_mr, iss, empty;
            lookup(u, d_rs1_used, d_rs1, sa, ha);
            lookup(u, d_rs2_used, d_rs2, sb, hb);
            br = s0_branch_taken;
            lu = d_valid & (ha | hb);
            go = 1'b0; e_sif = 1'b0; e_sd = 1'b0; e_fl = 1'b0; e_tr = 1'b0; e_mr = 1'b0; iss = 1'b0;
            empty = 1'b1;
            for (int a = 0; a < st_of(u); a++) if (m_v[u][a]) empty = 1'b0;
            if (m_mode[u] == 0) begin
                go    = irq & irq_en & d_valid & !br & !lu;
                e_sif = lu & !br;
                e_sd  = e_sif;
                e_mr  = d_is_mret & d_valid & !lu & !br & !go;
                e_fl  = br | e_mr;
                iss   = d_valid & !e_sd & !e_fl & !go;
            end else if (m_mode[u] == 1) begin
                e_sif = 1'b1;
                e_sd  = !br;
                e_fl  = br;
            end else begin
                e_tr = 1'b1;
                e_fl = 1'b1;
            end
            chk($sformatf("sel_a%0d", u), o_sa[u], 32'(sa));
            chk($sformatf("sel_b%0d", u), o_sb[u], 32'(sb));
            chk($sformatf("stall_if%0d", u), o_sif[u], 32'(e_sif));
            chk($sformatf("stall_d%0d", u), o_sd[u], 32'(e_sd));
            chk($sformatf("flush_d%0d", u), o_fl[u], 32'(e_fl));
            chk($sformatf("trap_take%0d", u), o_tr[u], 32'(e_tr));
            chk($sformatf("mret_take%0d", u), o_mr[u], 32'(e_mr));
            chk($sformatf("epc%0d", u), o_epc[u], m_epc[u]);
`ifdef HAZARD_PERF_CNT_EN
            chk($sformatf("perf_stall%0d", u), o_psc[u], m_cs[u]);
            chk($sformatf("perf_flush%0d", u), o_pfc[u], m_cf[u]);
`else
            chk($sformatf("perf_stall%0d", u), o_psc[u], 32'd0);
            chk($sformatf("perf_flush%0d", u), o_pfc[u], 32'd0);
`endif
            if (reset) begin
                m_cs[u] = m_cs[u] + 32'(e_sd);
                m_cf[u] = m_cf[u] + 32'(e_fl);
                for (int a = 7; a > 0; a--) begin
                    m_v[u][a] = m_v[u][a-1]; m_rd[u][a] = m_rd[u][a-1];
                    m_we[u][a] = m_we[u][a-1]; m_ld[u][a] = m_ld[u][a-1];
                end
                m_v[u][0] = iss; m_rd[u][0] = d_rd; m_we[u][0] = d_reg_we; m_ld[u][0] = d_is_load;
                if (m_mode[u] == 0 && go) begin
                    m_mode[u] = 1;
                    m_epc[u]  = d_pc;
                end else if (m_mode[u] == 1 && empty) begin
                    m_mode[u] = 2;
                end else if (m_mode[u] == 2) begin
                    m_mode[u] = 0;
                end
            end
        end
        if (!reset) model_reset();
        @(negedge clock);
    endtask

    task automatic idle();
        d_valid = 1'b0; d_rs1 = 5'd0; d_rs2 = 5'd0; d_rs1_used = 1'b0; d_rs2_used = 1'b0;
        d_rd = 5'd0; d_reg_we = 1'b0; d_is_load = 1'b0; d_is_mret = 1'b0; d_pc = 32'd0;
        s0_branch_taken = 1'b0; irq = 1'b0; irq_en = 1'b0;
    endtask

    task automatic instr(input bit [4:0] rd, input bit we, input bit ld, input bit [4:0] rs1, input bit u1,
                         input bit [4:0] rs2, input bit u2);
        idle();
        d_valid = 1'b1; d_rd = rd; d_reg_we = we; d_is_load = ld;
        d_rs1 = rs1; d_rs1_used = u1; d_rs2 = rs2; d_rs2_used = u2;
    endtask

    initial begin
        int drain0, trap0, trap_any;
        idle();
        reset = 1'b0;
        model_reset();
        settle();
        chk("rst_sel_a0", o_sa[0], 32'd0);
        chk("rst_epc1", o_epc[1], 32'd0);
        step();
        step();
        reset = 1'b1;

        // Back-to-back ALU dependency.
        instr(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1); settle(); step();
        instr(5'd10, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0); settle();
        chk("alu_fwd_a0", o_sa[0], 32'd1);
        chk("alu_nostall0", o_sd[0], 32'd0);
        step();
        idle(); for (int i = 0; i < 5; i++) begin settle(); step(); end

        // Load-use: one stall cycle on the 2-stage, two on the 4-stage.
        instr(5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle(); step();
        instr(5'd11, 1'b1, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0); settle();
        chk("lu_stall0_c1", o_sd[0], 32'd1);
        chk("lu_stall1_c1", o_sd[1], 32'd1);
        step(); settle();
        chk("lu_stall0_c2", o_sd[0], 32'd0);
        chk("lu_fwd0", o_sa[0], 32'd2);
        chk("lu_stall1_c2", o_sd[1], 32'd1);
        step(); settle();
        chk("lu_stall1_c3", o_sd[1], 32'd0);
        chk("lu_fwd1", o_sa[1], 32'd3);
        step();
        idle(); for (int i = 0; i < 5; i++) begin settle(); step(); end

        // Two writers of x7 in S0 and S2 on the 4-stage instance: youngest wins.
        instr(5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); settle(); step();
        instr(5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); settle(); step();
        instr(5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); settle(); step();
        instr(5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); settle();
        chk("youngest_b1", o_sb[1], 32'd1);
        step();
        idle(); for (int i = 0; i < 5; i++) begin settle(); step(); end

        // Branch during a load-use stall: flush wins, S0 entry stays valid.
        instr(5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle(); step();
        instr(5'd13, 1'b1, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0); s0_branch_taken = 1'b1; settle();
        chk("br_flush0", o_fl[0], 32'd1);
        chk("br_nostall0", o_sd[0], 32'd0);
        step();
        s0_branch_taken = 1'b0; settle();
        chk("br_s0kept_fwd0", o_sa[0], 32'd2);
        step();
        idle(); for (int i = 0; i < 5; i++) begin settle(); step(); end

        // Interrupt with one instruction in flight, then mret.
        instr(5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); d_pc = 32'h3c; settle(); step();
        instr(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); d_pc = 32'h40; irq = 1'b1; irq_en = 1'b1;
        settle(); step();
        irq = 1'b0;
        drain0 = 0; trap0 = 0;
        for (int i = 0; i < 8; i++) begin
            settle();
            drain0 += int'(sif0);
            trap0  += int'(tr0);
            step();
        end
        chk("irq_epc0", o_epc[0], 32'h40);
        chk("irq_drain_cycles0", 32'(drain0), 32'd2);
        chk("irq_trap_pulses0", 32'(trap0), 32'd1);
        instr(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); d_is_mret = 1'b1; d_pc = 32'h80; settle();
        chk("mret_take0", o_mr[0], 32'd1);
        chk("mret_epc0", o_epc[0], 32'h40);
        step();
        idle(); for (int i = 0; i < 5; i++) begin settle(); step(); end

        // Reset asserted mid-drain discards the pending trap.
        instr(5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); settle(); step();
        instr(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); d_pc = 32'h100; irq = 1'b1; irq_en = 1'b1;
        settle(); step();
        idle(); settle();
        chk("mid_drain0", o_sif[0], 32'd1);
        reset = 1'b0; #1; model_reset();
        step();
        reset = 1'b1;
        trap_any = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            trap_any += int'(tr0) + int'(tr1);
            step();
        end
        chk("rst_no_trap", 32'(trap_any), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            d_valid         = ($urandom_range(0, 3) != 0);
            d_rs1           = 5'($urandom_range(0, 3));
            d_rs2           = 5'($urandom_range(0, 3));
            d_rs1_used      = 1'($urandom_range(0, 1));
            d_rs2_used      = 1'($urandom_range(0, 1));
            d_rd            = 5'($urandom_range(0, 3));
            d_reg_we        = 1'($urandom_range(0, 1));
            d_is_load       = ($urandom_range(0, 2) == 0);
            d_is_mret       = ($urandom_range(0, 15) == 0);
            d_pc            = $urandom;
            s0_branch_taken = ($urandom_range(0, 7) == 0);
            irq             = ($urandom_range(0, 19) == 0);
            irq_en          = 1'($urandom_range(0, 1));
            settle();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
